rocc_cmd_issuer: RTL and testbench
==================================

# rocc_cmd_issuer

RoCC command initiator that sits on the CPU-side end of a RoCC accelerator port, in place of the core, for bring-up and latency characterisation. It accepts commands from a host-side request port into a small FIFO and issues them on the RoCC `io_cmd` channel. It tracks outstanding commands by destination register and matches `io_resp` beats back to them. It reports per-command round-trip latency in cycles, and flags unexpected responses and timeouts.

## Interface
- `QUEUE_DEPTH`, 4: host command FIFO entries; must be a power of 2, ≥2.
- `MAX_OUTSTANDING`, 4: tracker slots for commands with `xd=1`.
- `CNT_WIDTH`, 32: width of the timestamp and latency counters.
- `OPCODE`, 7'h0B: value driven on `io_cmd_bits_inst_opcode` (custom-0).
- `TIMEOUT`, 1024: slot age, in cycles, at which an outstanding command is abandoned.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `host_req_valid` / `host_req_ready`  in / out  1  host enqueue handshake.
- `host_req_funct`  in  7; `host_req_rd`  in  5; `host_req_xd`  in  1; `host_req_rs1`, `host_req_rs2`  in  64 each.
- `io_cmd_valid` / `io_cmd_ready`  out / in  1  RoCC command handshake.
- `io_cmd_bits_inst_funct`  out  7; `io_cmd_bits_inst_rd`  out  5; `io_cmd_bits_inst_opcode`  out  7.
- `io_cmd_bits_inst_rs1`, `io_cmd_bits_inst_rs2`  out  5  each driven 0.
- `io_cmd_bits_inst_xd`  out  1; `io_cmd_bits_inst_xs1`, `io_cmd_bits_inst_xs2`  out  1  each driven 1.
- `io_cmd_bits_rs1`, `io_cmd_bits_rs2`  out  64.
- `io_resp_valid` / `io_resp_ready`  in / out  1; `io_resp_bits_rd`  in  5; `io_resp_bits_data`  in  64.
- `res_valid` / `res_ready`  out / in  1  result handshake.
- `res_rd`  out  5; `res_data`  out  64; `res_latency`  out  `CNT_WIDTH`; `res_unexpected`  out  1.
- `outstanding`  out  `$clog2(MAX_OUTSTANDING+1)`  live tracker occupancy.
- `issued_count`  out  `CNT_WIDTH`  total `io_cmd` handshakes.
- `timeout_err`  out  1  sticky; `timeout_rd`  out  5  rd of the last timed-out slot; `err_clear`  in  1  clears `timeout_err`.

## Operation
- **Free-running timestamp** `now` (`CNT_WIDTH` bits) increments every cycle and wraps. All differences are taken modulo 2^`CNT_WIDTH`.
- **Host FIFO**
  - `host_req_ready = !fifo_full`.
  - An enqueue writes registered storage.
  - The head drives the `io_cmd_bits_*` fields directly.
- **Issue eligibility**: the head is eligible if the FIFO is non-empty and either:
  - `xd=0`, or
  - `xd=1`, a free slot exists, and no valid slot holds the same rd (rd hazard).
- **`io_cmd_valid`**
  - Equals head eligibility, evaluated on registered state only.
  - Once asserted it stays asserted, with fields stable, until `io_cmd_ready`. Eligibility can only grow while waiting.
- **On `io_cmd` handshake**
  - Pop the FIFO; increment `issued_count`.
  - If `xd=1`, allocate the lowest-index free slot {valid, rd, start=`now`}.
  - `xd=0` commands are fire-and-forget: no slot, no result.
- **Response port**
  - `io_resp_ready = !res_valid || res_ready`.
  - On an `io_resp` handshake, search the slots for a valid match on rd:
    - Hit: free the slot; load the result register with {rd, data, `now - start`, unexpected=0}.
    - Miss: load {rd, data, 0, unexpected=1}.
  - `res_valid` is set at the next edge and cleared on `res_ready` unless a new response loads in the same cycle.
- **Timeout**
  - Any valid slot with `now - start == TIMEOUT` is freed, sets `timeout_err`, and loads `timeout_rd`.
  - If several slots time out together, `timeout_rd` takes the highest index.
  - A response hitting that slot in the same cycle wins: normal result, no timeout.
  - A later response for that rd is reported as unexpected.
- **Error clear**: `err_clear` clears `timeout_err`. A timeout in the same cycle wins.
- **Reset**
  - Resets all state: FIFO empty, slots invalid, `now`=0, counters 0, result register invalid.
  - In-flight commands are dropped. Mid-operation reset discards pending results with no output.

## Timing
- **Outputs after reset**:
  - 0: `io_cmd_valid`, `res_*`, `outstanding`, `issued_count`, `timeout_err`, `timeout_rd`, `io_cmd_bits_*` (FIFO storage cleared).
  - 1: `host_req_ready`, `io_resp_ready`.
  - Constants: `xs1`/`xs2` = 1 and opcode = `OPCODE` at all times.
- **Enqueue to issue**: host handshake at edge N means `io_cmd_valid` is high in cycle N+1 if eligible. Back-to-back issue is 1 command per cycle.
- **Latency definition**: latency = (cycle of `io_resp` handshake) − (cycle of `io_cmd` handshake). A same-cycle response is impossible; the minimum reported is 1.
- **Result timing**: `res_valid` is asserted the cycle after the `io_resp` handshake.
- **Slot reuse**: a slot freed by a response or timeout in cycle N is allocatable from cycle N+1. Allocation and free in the same cycle are both applied.
- **Occupancy**: `outstanding` updates at the edge of allocate/free, with net change −1, 0 or +1 (0 when one is allocated and one freed). Multiple timeouts in one cycle may subtract more.
- **FIFO full**: `host_req_ready` goes low. Simultaneous enqueue and issue when full is not allowed, because ready is low.

## Test plan
- **Single command**: enqueue funct=3, rd=5, xd=1; responder answers rd=5 data=6 exactly 10 cycles after the cmd handshake. Required: `res_valid` with rd=5, data=6, latency=10, unexpected=0; `outstanding` goes 1 then 0.
- **rd hazard**: enqueue two xd=1 commands with rd=7. Required: the second stays at the head with `io_cmd_valid`=0 until the first response handshake, then issues the next cycle.
- **Full tracker and FIFO**: 4 commands with distinct rd plus 4 more queued, responder silent. Required: `outstanding`=4, `host_req_ready`=0. One response then allows exactly one further issue.
- **Unexpected response**: `io_resp` with rd=9 and nothing outstanding. Required: result with unexpected=1 and latency=0.
- **Timeout**: TIMEOUT=16, issue rd=2, no response. Required: `timeout_err`=1 and `timeout_rd`=2 exactly 16 cycles after issue, slot freed. A late response on rd=2 reports unexpected=1; `err_clear` drops the flag.
- **Backpressure**: hold `res_ready`=0 with one result pending. Required: `io_resp_ready`=0 and the result is held stable. Setting `res_ready`=1 with a new response in the same cycle loads the new result with `res_valid` continuously high.

Source files
------------

// File: rtl/rocc_cmd_issuer.sv
// Host-fed RoCC command initiator with outstanding-command tracking,
// round-trip latency measurement, unexpected-response and timeout flags.
module rocc_cmd_issuer #(
    parameter int         QUEUE_DEPTH     = 4,
    parameter int         MAX_OUTSTANDING = 4,
    parameter int         CNT_WIDTH       = 32,
    parameter logic [6:0] OPCODE          = 7'h0B,
    parameter int         TIMEOUT         = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 host_req_valid,
    output logic                 host_req_ready,
    input  logic [6:0]           host_req_funct,
    input  logic [4:0]           host_req_rd,
    input  logic                 host_req_xd,
    input  logic [63:0]          host_req_rs1,
    input  logic [63:0]          host_req_rs2,
    output logic                 io_cmd_valid,
    input  logic                 io_cmd_ready,
    output logic [6:0]           io_cmd_bits_inst_funct,
    output logic [4:0]           io_cmd_bits_inst_rd,
    output logic [6:0]           io_cmd_bits_inst_opcode,
    output logic [4:0]           io_cmd_bits_inst_rs1,
    output logic [4:0]           io_cmd_bits_inst_rs2,
    output logic                 io_cmd_bits_inst_xd,
    output logic                 io_cmd_bits_inst_xs1,
    output logic                 io_cmd_bits_inst_xs2,
    output logic [63:0]          io_cmd_bits_rs1,
    output logic [63:0]          io_cmd_bits_rs2,
    input  logic                 io_resp_valid,
    output logic                 io_resp_ready,
    input  logic [4:0]           io_resp_bits_rd,
    input  logic [63:0]          io_resp_bits_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4:0]           res_rd,
    output logic [63:0]          res_data,
    output logic [CNT_WIDTH-1:0] res_latency,
    output logic                 res_unexpected,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [CNT_WIDTH-1:0] issued_count,
    output logic                 timeout_err,
    output logic [4:0]           timeout_rd,
    input  logic                 err_clear
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int N  = MAX_OUTSTANDING;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    typedef struct packed {
        logic [6:0]  funct;
        logic [4:0]  rd;
        logic        xd;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } cmd_t;

    cmd_t                 mem [QUEUE_DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    cmd_t                 head;
    logic                 empty;
    logic                 full;
    logic [CNT_WIDTH-1:0] now;
    logic [N-1:0]         slot_v;
    logic [4:0]           slot_rd [N];
    logic [CNT_WIDTH-1:0] slot_start [N];

    logic                 host_fire;
    logic                 cmd_fire;
    logic                 resp_fire;
    logic [N-1:0]         head_match;
    logic [N-1:0]         resp_match;
    logic [N-1:0]         hit_oh;
    logic [N-1:0]         alloc_oh;
    logic [N-1:0]         to_vec;
    logic [N-1:0]         free_vec;
    logic [CNT_WIDTH-1:0] hit_start;
    logic [4:0]           to_rd;
    logic [OW-1:0]        occ;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    assign host_req_ready = !full;
    assign io_resp_ready  = !res_valid || res_ready;
    assign io_cmd_valid   = !empty &&
                            (!head.xd || (!(&slot_v) && !(|head_match)));

    assign host_fire = host_req_valid && host_req_ready;
    assign cmd_fire  = io_cmd_valid && io_cmd_ready;
    assign resp_fire = io_resp_valid && io_resp_ready;

    assign io_cmd_bits_inst_funct  = head.funct;
    assign io_cmd_bits_inst_rd     = head.rd;
    assign io_cmd_bits_inst_xd     = head.xd;
    assign io_cmd_bits_rs1         = head.rs1;
    assign io_cmd_bits_rs2         = head.rs2;
    assign io_cmd_bits_inst_opcode = OPCODE;
    assign io_cmd_bits_inst_rs1    = 5'd0;
    assign io_cmd_bits_inst_rs2    = 5'd0;
    assign io_cmd_bits_inst_xs1    = 1'b1;
    assign io_cmd_bits_inst_xs2    = 1'b1;
    assign outstanding             = occ;

    always_comb begin
        head_match = '0;
        resp_match = '0;
        to_vec     = '0;
        hit_start  = '0;
        to_rd      = '0;
        occ        = '0;
        for (int i = 0; i < N; i++) begin
            head_match[i] = slot_v[i] && (slot_rd[i] == head.rd);
            resp_match[i] = slot_v[i] && (slot_rd[i] == io_resp_bits_rd);
            occ = occ + OW'(slot_v[i]);
        end
        hit_oh   = resp_fire ? (resp_match & (~resp_match + N'(1))) : '0;
        alloc_oh = (cmd_fire && head.xd) ? (~slot_v & (slot_v + N'(1))) : '0;
        // Ascending scan: the highest timed-out index supplies timeout_rd.
        for (int i = 0; i < N; i++) begin
            if (hit_oh[i]) hit_start = slot_start[i];
            if (slot_v[i] && !hit_oh[i] && (now - slot_start[i] == TMO)) begin
                to_vec[i] = 1'b1;
                to_rd     = slot_rd[i];
            end
        end
        free_vec = hit_oh | to_vec;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (host_fire) begin
                mem[wptr[AW-1:0]] <= '{host_req_funct, host_req_rd,
                                       host_req_xd, host_req_rs1,
                                       host_req_rs2};
                wptr <= wptr + 1'b1;
            end
            if (cmd_fire) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            now          <= '0;
            issued_count <= '0;
        end else begin
            now <= now + 1'b1;
            if (cmd_fire) issued_count <= issued_count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_v <= '0;
            for (int i = 0; i < N; i++) begin
                slot_rd[i]    <= '0;
                slot_start[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc_oh[i]) begin
                    slot_v[i]     <= 1'b1;
                    slot_rd[i]    <= head.rd;
                    slot_start[i] <= now;
                end else if (free_vec[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid      <= 1'b0;
            res_rd         <= '0;
            res_data       <= '0;
            res_latency    <= '0;
            res_unexpected <= 1'b0;
        end else if (resp_fire) begin
            res_valid      <= 1'b1;
            res_rd         <= io_resp_bits_rd;
            res_data       <= io_resp_bits_data;
            res_latency    <= (|hit_oh) ? (now - hit_start) : '0;
            res_unexpected <= !(|hit_oh);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
            timeout_rd  <= '0;
        end else if (|to_vec) begin
            timeout_err <= 1'b1;
            timeout_rd  <= to_rd;
        end else if (err_clear) begin
            timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Bench for rocc_cmd_issuer: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_rocc_cmd_issuer;
    localparam int TMO   = 16;
    localparam int DEPTH = 4;
    localparam int SLOTS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        host_req_valid, host_req_ready;
    logic [6:0]  host_req_funct;
    logic [4:0]  host_req_rd;
    logic        host_req_xd;
    logic [63:0] host_req_rs1, host_req_rs2;
    logic        io_cmd_valid, io_cmd_ready;
    logic [6:0]  c_funct, c_opcode;
    logic [4:0]  c_rd, c_irs1, c_irs2;
    logic        c_xd, c_xs1, c_xs2;
    logic [63:0] c_rs1, c_rs2;
    logic        io_resp_valid, io_resp_ready;
    logic [4:0]  io_resp_bits_rd;
    logic [63:0] io_resp_bits_data;
    logic        res_valid, res_ready;
    logic [4:0]  res_rd;
    logic [63:0] res_data;
    logic [31:0] res_latency;
    logic        res_unexpected;
    logic [2:0]  outstanding;
    logic [31:0] issued_count;
    logic        timeout_err;
    logic [4:0]  timeout_rd;
    logic        err_clear;

    always #5 clock = ~clock;

    rocc_cmd_issuer #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_funct(host_req_funct), .host_req_rd(host_req_rd),
        .host_req_xd(host_req_xd), .host_req_rs1(host_req_rs1),
        .host_req_rs2(host_req_rs2),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_bits_inst_funct(c_funct), .io_cmd_bits_inst_rd(c_rd),
        .io_cmd_bits_inst_opcode(c_opcode), .io_cmd_bits_inst_rs1(c_irs1),
        .io_cmd_bits_inst_rs2(c_irs2), .io_cmd_bits_inst_xd(c_xd),
        .io_cmd_bits_inst_xs1(c_xs1), .io_cmd_bits_inst_xs2(c_xs2),
        .io_cmd_bits_rs1(c_rs1), .io_cmd_bits_rs2(c_rs2),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_bits_rd(io_resp_bits_rd),
        .io_resp_bits_data(io_resp_bits_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
        .res_data(res_data), .res_latency(res_latency),
        .res_unexpected(res_unexpected), .outstanding(outstanding),
        .issued_count(issued_count), .timeout_err(timeout_err),
        .timeout_rd(timeout_rd), .err_clear(err_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [6:0]  funct;
        logic [4:0]  rd;
        logic        xd;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } cmd_s;

    cmd_s        mq[$];
    bit          mv [SLOTS];
    logic [4:0]  mrd [SLOTS];
    logic [31:0] mst [SLOTS];
    logic [31:0] m_now, m_issued, m_rlat;
    bit          m_rv, m_runexp, m_terr;
    logic [4:0]  m_rrd, m_trd;
    logic [63:0] m_rdata;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < SLOTS; i++) begin
            mv[i] = 0; mrd[i] = '0; mst[i] = '0;
        end
        m_now = 0; m_issued = 0; m_rv = 0; m_rrd = 0;
        m_rdata = 0; m_rlat = 0; m_runexp = 0; m_terr = 0; m_trd = 0;
    endtask

    function automatic bit m_elig();
        bit has_free = 0;
        bit haz = 0;
        if (mq.size() == 0) return 0;
        if (!mq[0].xd) return 1;
        for (int i = 0; i < SLOTS; i++) begin
            if (!mv[i]) has_free = 1;
            if (mv[i] && mrd[i] == mq[0].rd) haz = 1;
        end
        return has_free && !haz;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) n += int'(mv[i]);
        return n;
    endfunction

    // Compare one cycle of DUT outputs to the model, then advance both.
    task automatic step();
        bit   elig, hrdy, rrdy, hfire, ifire, rfire, to_any;
        bit   fr [SLOTS];
        int   hit, ai;
        cmd_s c;
        #1;
        elig = m_elig();
        hrdy = mq.size() < DEPTH;
        rrdy = !m_rv || res_ready;
        check("host_ready", host_req_ready, hrdy);
        check("resp_ready", io_resp_ready, rrdy);
        check("cmd_valid", io_cmd_valid, elig);
        if (elig) begin
            check("cmd_funct", c_funct, mq[0].funct);
            check("cmd_rd", c_rd, mq[0].rd);
            check("cmd_xd", c_xd, mq[0].xd);
            check("cmd_rs1", c_rs1, mq[0].rs1);
            check("cmd_rs2", c_rs2, mq[0].rs2);
        end
        check("res_valid", res_valid, m_rv);
        if (m_rv) begin
            check("res_rd", res_rd, m_rrd);
            check("res_data", res_data, m_rdata);
            check("res_lat", res_latency, m_rlat);
            check("res_unexp", res_unexpected, m_runexp);
        end
        check("outstanding", outstanding, m_occ());
        check("issued", issued_count, m_issued);
        check("terr", timeout_err, m_terr);
        check("trd", timeout_rd, m_trd);
        check("consts", {c_opcode, c_xs1, c_xs2, c_irs1, c_irs2},
              {7'h0B, 1'b1, 1'b1, 5'd0, 5'd0});

        hfire = host_req_valid && hrdy;
        ifire = elig && io_cmd_ready;
        rfire = io_resp_valid && rrdy;
        hit = -1;
        ai  = -1;
        to_any = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rfire && hit < 0 && mv[i] && mrd[i] == io_resp_bits_rd)
                hit = i;
            if (ai < 0 && !mv[i]) ai = i;
        end
        for (int i = 0; i < SLOTS; i++) begin
            fr[i] = 0;
            if (mv[i] && i != hit && (m_now - mst[i]) == TMO) begin
                fr[i] = 1; to_any = 1; m_trd = mrd[i];
            end
        end
        if (rfire) begin
            m_rv = 1; m_rrd = io_resp_bits_rd; m_rdata = io_resp_bits_data;
            m_runexp = (hit < 0);
            m_rlat = (hit < 0) ? 32'd0 : m_now - mst[hit];
        end else if (res_ready) begin
            m_rv = 0;
        end
        if (hit >= 0) mv[hit] = 0;
        for (int i = 0; i < SLOTS; i++) if (fr[i]) mv[i] = 0;
        if (to_any) m_terr = 1;
        else if (err_clear) m_terr = 0;
        if (ifire) begin
            c = mq.pop_front();
            m_issued++;
            if (c.xd) begin
                mv[ai] = 1; mrd[ai] = c.rd; mst[ai] = m_now;
            end
        end
        if (hfire) begin
            c.funct = host_req_funct; c.rd = host_req_rd;
            c.xd = host_req_xd; c.rs1 = host_req_rs1; c.rs2 = host_req_rs2;
            mq.push_back(c);
        end
        m_now++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        host_req_valid = 0; host_req_funct = 0; host_req_rd = 0;
        host_req_xd = 0; host_req_rs1 = 0; host_req_rs2 = 0;
        io_cmd_ready = 1; io_resp_valid = 0; io_resp_bits_rd = 0;
        io_resp_bits_data = 0; res_ready = 1; err_clear = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle();
        repeat (2) @(negedge clock);
        model_reset();
        reset = 1;
    endtask

    task automatic enq(input logic [6:0] f, input logic [4:0] rd,
                       input logic xd);
        host_req_valid = 1; host_req_funct = f; host_req_rd = rd;
        host_req_xd = xd;
        host_req_rs1 = {$urandom, $urandom};
        host_req_rs2 = {$urandom, $urandom};
    endtask

    task automatic resp(input logic [4:0] rd, input logic [63:0] d);
        io_resp_valid = 1; io_resp_bits_rd = rd; io_resp_bits_data = d;
    endtask

    task automatic rand_inputs();
        logic [4:0] cand[$];
        host_req_valid = ($urandom_range(0, 1) == 1);
        host_req_funct = 7'($urandom);
        host_req_rd = 5'($urandom_range(0, 7));
        host_req_xd = ($urandom_range(0, 3) != 0);
        host_req_rs1 = {$urandom, $urandom};
        host_req_rs2 = {$urandom, $urandom};
        io_cmd_ready = ($urandom_range(0, 9) < 7);
        res_ready = ($urandom_range(0, 9) < 7);
        err_clear = ($urandom_range(0, 19) == 0);
        io_resp_valid = ($urandom_range(0, 9) < 2);
        io_resp_bits_data = {$urandom, $urandom};
        for (int i = 0; i < SLOTS; i++) if (mv[i]) cand.push_back(mrd[i]);
        if (cand.size() > 0 && $urandom_range(0, 9) < 8)
            io_resp_bits_rd = cand[$urandom_range(0, cand.size() - 1)];
        else
            io_resp_bits_rd = 5'($urandom);
    endtask

    initial begin
        idle();
        reset = 0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_cmd_valid", io_cmd_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_fields", {res_rd, res_latency, res_unexpected}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_issued", issued_count, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_trd", timeout_rd, 0);
        check("rst_host_ready", host_req_ready, 1);
        check("rst_resp_ready", io_resp_ready, 1);
        check("rst_cmd_fields", {c_funct, c_rd, c_xd}, 0);
        check("rst_cmd_rs1", c_rs1, 0);
        check("rst_cmd_rs2", c_rs2, 0);
        check("rst_opcode", c_opcode, 7'h0B);
        check("rst_xs", {c_xs1, c_xs2}, 2'b11);
        @(negedge clock);
        model_reset();
        reset = 1;

        // single command, response 10 cycles after issue
        enq(7'd3, 5'd5, 1'b1);
        step();
        host_req_valid = 0;
        step();
        check("single_occ1", outstanding, 1);
        repeat (9) step();
        resp(5'd5, 64'd6);
        step();
        io_resp_valid = 0;
        check("single_valid", res_valid, 1);
        check("single_rd", res_rd, 5);
        check("single_data", res_data, 6);
        check("single_lat", res_latency, 10);
        check("single_unexp", res_unexpected, 0);
        check("single_occ0", outstanding, 0);

        // rd hazard
        do_reset();
        enq(7'd1, 5'd7, 1'b1);
        step();
        enq(7'd2, 5'd7, 1'b1);
        step();
        host_req_valid = 0;
        repeat (3) begin
            check("haz_hold", io_cmd_valid, 0);
            step();
        end
        resp(5'd7, 64'h77);
        step();
        io_resp_valid = 0;
        check("haz_go", io_cmd_valid, 1);
        check("haz_go_funct", c_funct, 2);
        step();
        check("haz_occ", outstanding, 1);

        // full tracker and FIFO
        do_reset();
        for (int k = 0; k < 8; k++) begin
            enq(7'(k), 5'(10 + k), 1'b1);
            step();
        end
        host_req_valid = 0;
        check("full_occ", outstanding, 4);
        check("full_host_ready", host_req_ready, 0);
        check("full_cmd_valid", io_cmd_valid, 0);
        resp(5'd10, 64'h1010);
        step();
        io_resp_valid = 0;
        check("full_one_issue", io_cmd_valid, 1);
        check("full_one_rd", c_rd, 14);
        step();
        check("full_occ_again", outstanding, 4);
        check("full_stall_again", io_cmd_valid, 0);
        check("full_host_ready2", host_req_ready, 1);
        step();

        // unexpected response
        do_reset();
        resp(5'd9, 64'hdead_beef_0123_4567);
        step();
        io_resp_valid = 0;
        check("unexp_valid", res_valid, 1);
        check("unexp_flag", res_unexpected, 1);
        check("unexp_lat", res_latency, 0);
        check("unexp_rd", res_rd, 9);
        check("unexp_data", res_data, 64'hdead_beef_0123_4567);

        // timeout
        do_reset();
        enq(7'h11, 5'd2, 1'b1);
        step();
        host_req_valid = 0;
        step();
        repeat (15) step();
        check("to_before", timeout_err, 0);
        check("to_before_occ", outstanding, 1);
        step();
        check("to_err", timeout_err, 1);
        check("to_rd", timeout_rd, 2);
        check("to_occ", outstanding, 0);
        resp(5'd2, 64'h22);
        step();
        io_resp_valid = 0;
        check("to_late_unexp", res_unexpected, 1);
        err_clear = 1;
        step();
        err_clear = 0;
        check("to_cleared", timeout_err, 0);

        // backpressure
        do_reset();
        res_ready = 0;
        resp(5'd9, 64'h1111_2222_3333_4444);
        step();
        io_resp_valid = 0;
        repeat (3) begin
            check("bp_valid", res_valid, 1);
            check("bp_resp_ready", io_resp_ready, 0);
            check("bp_data", res_data, 64'h1111_2222_3333_4444);
            step();
        end
        res_ready = 1;
        resp(5'd4, 64'h5555_6666_7777_8888);
        #1;
        check("bp_release_ready", io_resp_ready, 1);
        step();
        io_resp_valid = 0;
        check("bp_new_valid", res_valid, 1);
        check("bp_new_data", res_data, 64'h5555_6666_7777_8888);
        check("bp_new_rd", res_rd, 4);

        // random traffic with one mid-run reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            step();
            if (n == 1500) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
